// File: rtl/psg_pkg.sv
// Shared definitions for the PSG noise/tone block: register addresses,
// envelope shape bit positions, envelope run mode and the volume table.
package psg_pkg;

  localparam logic [4:0] A_TONE   = 5'h00;
  localparam logic [4:0] A_NOISE  = 5'h10;
  localparam logic [4:0] A_TDIS   = 5'h11;
  localparam logic [4:0] A_NDIS   = 5'h12;
  localparam logic [4:0] A_ENV_LO = 5'h14;
  localparam logic [4:0] A_ENV_HI = 5'h15;
  localparam logic [4:0] A_SHAPE  = 5'h16;
  localparam logic [4:0] A_VOL    = 5'h18;

  localparam int SH_HOLD = 0;
  localparam int SH_ALT  = 1;
  localparam int SH_ATT  = 2;
  localparam int SH_CONT = 3;

  typedef enum logic {
    ENV_RUN,
    ENV_HOLD
  } env_mode_t;

  // Pseudo-log volume curve: {1,v[0],1} shifted by v[3:1]; zero is silent.
  function automatic logic [9:0] vol_tbl(input logic [3:0] v);
    logic [9:0] base;
    base = {7'b0, 1'b1, v[0], 1'b1};
    if (v == 4'h0) return '0;
    return base << v[3:1];
  endfunction

endpackage

// File: rtl/psg_tone_ch.sv
// Period counter with toggle output; used for tone channels, noise clock
// and envelope step clock. clr restarts the counter on the next clken.
module psg_tone_ch #(
  parameter int PW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  input  logic          clr,
  input  logic [PW-1:0] period,
  output logic          tone,
  output logic          expire
);

  logic [PW-1:0] cnt;
  logic [PW:0]   nxt;
  logic [PW:0]   lim;

  // Period 0 behaves as 1; >= lets a shortened period expire at once.
  always_comb begin
    nxt    = {1'b0, cnt} + {{PW{1'b0}}, 1'b1};
    lim    = (period == '0) ? {{PW{1'b0}}, 1'b1} : {1'b0, period};
    expire = clken & ~clr & (nxt >= lim);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (clken) begin
      if (clr) begin
        cnt <= '0;
      end else if (expire) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= nxt[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/psg_nch.sv
// AY-style programmable sound generator with CH tone channels, one noise
// source and an envelope. Define PSG_READ_EN to build register readback.
module psg_nch #(
  parameter int CH = 3,
  parameter int TW = 12,
  parameter int DW = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clken,
  input  logic           wr_en,
  input  logic           rd_en,
  input  logic [4:0]     addr,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata,
  output logic [CH*DW-1:0] ch_out,
  output logic [DW+2:0]  mix_out
);
  import psg_pkg::*;

  logic [TW-1:0] tper [CH];
  logic [4:0]    vol  [CH];
  logic [CH-1:0] tdis, ndis;
  logic [4:0]    nper;
  logic [15:0]   eper;
  logic [3:0]    shape;
  logic          wr_shape;

  assign wr_shape = wr_en && (addr == A_SHAPE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) begin
        tper[i] <= '0;
        vol[i]  <= '0;
      end
      tdis  <= '1;
      ndis  <= '1;
      nper  <= '0;
      eper  <= '0;
      shape <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (addr == 5'(A_TONE + 2*i))     tper[i][7:0]    <= wdata;
        if (addr == 5'(A_TONE + 2*i + 1)) tper[i][TW-1:8] <= wdata[TW-9:0];
        if (addr == 5'(A_VOL + i))        vol[i]          <= wdata[4:0];
      end
      case (addr)
        A_NOISE:  nper       <= wdata[4:0];
        A_TDIS:   tdis       <= wdata[CH-1:0];
        A_NDIS:   ndis       <= wdata[CH-1:0];
        A_ENV_LO: eper[7:0]  <= wdata;
        A_ENV_HI: eper[15:8] <= wdata;
        A_SHAPE:  shape      <= wdata[3:0];
        default: ;
      endcase
    end
  end

  logic [CH-1:0] tone_bit;
  logic [CH-1:0] tone_exp_unused;

  for (genvar g = 0; g < CH; g++) begin : g_tone
    psg_tone_ch #(.PW(TW)) u_tone (
      .clk    (clk),
      .rst    (rst),
      .clken  (clken),
      .clr    (1'b0),
      .period (tper[g]),
      .tone   (tone_bit[g]),
      .expire (tone_exp_unused[g])
    );
  end

  logic        noise_exp, noise_tone_unused;
  logic [16:0] lfsr;

  psg_tone_ch #(.PW(5)) u_noise (
    .clk    (clk),
    .rst    (rst),
    .clken  (clken),
    .clr    (1'b0),
    .period (nper),
    .tone   (noise_tone_unused),
    .expire (noise_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            lfsr <= 17'h00001;
    else if (noise_exp) lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
  end

  // Envelope: a shape write arms a restart that fires on the next clken,
  // pre-empting any step advance on that same tick.
  logic      env_pend, env_clr, env_exp, env_tone_unused, env_att, env_dir;
  logic [3:0] env_step, hold_lvl, env_lvl;
  env_mode_t env_mode;

  assign env_clr = env_pend | wr_shape;
  assign env_att = wr_shape ? wdata[SH_ATT] : shape[SH_ATT];

  psg_tone_ch #(.PW(16)) u_env (
    .clk    (clk),
    .rst    (rst),
    .clken  (clken),
    .clr    (env_clr),
    .period (eper),
    .tone   (env_tone_unused),
    .expire (env_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_pend <= 1'b0;
      env_step <= '0;
      env_dir  <= 1'b0;
      hold_lvl <= '0;
      env_mode <= ENV_RUN;
    end else begin
      if (clken)         env_pend <= 1'b0;
      else if (wr_shape) env_pend <= 1'b1;

      if (clken && env_clr) begin
        env_step <= '0;
        env_dir  <= env_att;
        env_mode <= ENV_RUN;
      end else if (env_exp && env_mode == ENV_RUN) begin
        if (env_step != 4'hF) begin
          env_step <= env_step + 4'd1;
        end else if (!shape[SH_CONT]) begin
          hold_lvl <= '0;
          env_mode <= ENV_HOLD;
        end else if (shape[SH_HOLD]) begin
          hold_lvl <= {4{env_dir ^ shape[SH_ALT]}};
          env_mode <= ENV_HOLD;
        end else begin
          env_step <= '0;
          env_dir  <= env_dir ^ shape[SH_ALT];
        end
      end
    end
  end

  assign env_lvl = (env_mode == ENV_HOLD) ? hold_lvl
                 : (env_dir ? env_step : ~env_step);

  logic             noise;
  logic [3:0]       v;
  logic [CH*DW-1:0] ch_next;
  logic [DW+2:0]    mix_sum;

  assign noise = lfsr[0];

  always_comb begin
    v       = '0;
    ch_next = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      v = vol[i][4] ? env_lvl : vol[i][3:0];
      if ((tone_bit[i] | tdis[i]) & (noise | ndis[i]))
        ch_next[i*DW +: DW] = DW'(vol_tbl(v)) << (DW - 10);
    end
  end

  always_comb begin
    mix_sum = '0;
    for (int unsigned i = 0; i < CH; i++)
      mix_sum = mix_sum + (DW+3)'(ch_out[i*DW +: DW]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_out  <= '0;
      mix_out <= '0;
    end else begin
      ch_out  <= ch_next;
      mix_out <= mix_sum;
    end
  end

`ifdef PSG_READ_EN
  logic [7:0]  rd_val;
  logic [15:0] tp;

  always_comb begin
    rd_val = '0;
    tp     = '0;
    case (addr)
      A_NOISE:  rd_val = {3'b0, nper};
      A_TDIS:   rd_val = 8'(tdis);
      A_NDIS:   rd_val = 8'(ndis);
      A_ENV_LO: rd_val = eper[7:0];
      A_ENV_HI: rd_val = eper[15:8];
      A_SHAPE:  rd_val = {4'b0, shape};
      default: ;
    endcase
    for (int unsigned i = 0; i < CH; i++) begin
      tp = 16'(tper[i]);
      if (addr == 5'(A_TONE + 2*i))     rd_val = tp[7:0];
      if (addr == 5'(A_TONE + 2*i + 1)) rd_val = tp[15:8];
      if (addr == 5'(A_VOL + i))        rd_val = {3'b0, vol[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= rd_val;
  end
`else
  logic rd_unused;
  assign rd_unused = rd_en;
  assign rdata     = '0;
`endif

endmodule
